hamming_acc_seq: RTL
====================

# hamming_acc_seq

Parametrised sequential Hamming-distance accumulator: consumes two operand streams W bits per beat over NBEATS beats and produces the total count of differing bit positions. A registered threshold comparison accompanies the result. It generalises the single-bit-per-cycle, free-running Hamming counter into a start/done framed, back-pressurable, multi-bit-per-beat engine. It sits in the garbled-circuit benchmark netlist set as a drop-in sequential distance kernel.

## Interface
- W, default 8, operand bits consumed per accepted beat (≥1)
- NBEATS, default 2000, beats per computation (≥1)
- OW, default $clog2(W*NBEATS+1), result width (derived, not overridden)
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge)
- start  in  1  begin a new computation; honoured only in IDLE or DONE
- thr  in  OW  threshold, sampled on an honoured start
- x  in  W  operand A beat
- y  in  W  operand B beat
- in_valid  in  1  x/y beat present
- in_ready  out  1  engine can accept a beat; high only in ACC
- o  out  OW  running / final Hamming count
- done  out  1  result valid; high in DONE
- le_thr  out  1  final o ≤ sampled thr; valid only while done==1, otherwise 0

## Operation
- States: IDLE, ACC, DONE.
- IDLE: in_ready=0, done=0, o holds 0. start → ACC; clear o and the beat counter; latch thr.
- ACC: in_ready=1. A beat is accepted when in_valid && in_ready, and then o ← o + popcount(x ^ y). Beats with in_valid=0 are stalls and leave o unchanged. The beat counter (width $clog2(NBEATS)) increments per accepted beat. Acceptance of beat NBEATS-1 → DONE.
- start while in ACC is ignored; the computation is not restarted.
- DONE: done=1, in_ready=0. o holds the final sum. le_thr = (o ≤ thr_latched), registered at the same edge as the transition. start → ACC with o, counter and thr reset and re-latched exactly as from IDLE. Without start, the block stays in DONE indefinitely.
- Arithmetic: popcount is W→$clog2(W+1) bits, zero-extended to OW. The sum cannot overflow by construction (max W*NBEATS).
- rst==0 at any state, including mid-ACC: next state IDLE, o=0, done=0, le_thr=0, in_ready=0. Any partial sum is discarded.
- rst==0 and start asserted together: reset wins.

## Timing
- Reset values: o=0, done=0, le_thr=0, in_ready=0.
- start sampled at edge k → in_ready=1 from cycle k+1.
- Accepted beat at edge k → updated o visible after edge k (one-cycle latency, no pipeline).
- Final beat accepted at edge k → done=1, le_thr valid, in_ready=0 from cycle k+1.
- Minimum computation: 1 start cycle + NBEATS beat cycles. done rises NBEATS+1 edges after start with no stalls.
- in_ready does not depend combinationally on in_valid.

## Structure
- Package hamming_pkg:
  - state enum (IDLE, ACC, DONE)
  - localparam helper for OW
  - popcount width function
- Sub-module hamming_popcount #(W):
  - purely combinational balanced adder tree
  - input: x^y
  - output: count of width $clog2(W+1)
- Top level contains:
  - FSM
  - beat counter
  - accumulator
  - threshold register
  - compare flop

## Test plan
- W=8, NBEATS=4, thr=40. start, then 4 beats of x=8'hFF, y=8'h00, in_valid continuous → o=32 after beat 4, done=1, le_thr=1, done exactly 5 edges after start.
- W=8, NBEATS=4, thr=3. Beats x^y = 8'h01, 8'h03, 8'h00, 8'h80 → o=1,3,3,4 per beat; final o=4, le_thr=0.
- Stalls: the same stream as the previous scenario with in_valid low for 3 cycles between beats 2 and 3 → o holds 3 across the stall, final o=4, done delayed by 3 cycles.
- start pulsed during ACC after beat 1 → ignored. Final o equals the unstalled result.
- Restart from DONE: start with a new thr=0 and all-equal beats → o returns to 0 one cycle after start, final o=0, le_thr=1.
- rst=0 for one cycle after beat 2 → next cycle o=0, in_ready=0, done=0, state IDLE. The following start runs a clean computation to o=32 with the first test's stimulus.

Source files
------------

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hamming_pkg
// Purpose  : Shared types and width helpers for the Hamming-distance
//            accumulator: FSM state encoding, result / popcount / beat
//            counter width calculations.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to count the ones in a w-bit vector (0..w inclusive).
  function automatic int popcnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Result width: the total can reach w*nb, so it needs room for that value.
  function automatic int ow_calc(input int w, input int nb);
    return $clog2(w * nb + 1);
  endfunction

  // Beat counter width; a single-beat engine still needs one bit of storage.
  function automatic int beat_cnt_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/hamming_acc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : hamming_acc_seq_if
// Purpose  : Framing / stream / result bundle of the Hamming accumulator.
// Ports    : start, thr     - command side (master -> slave)
//            x, y, in_valid - operand beat (master -> slave)
//            in_ready       - beat acceptance (slave -> master)
//            o, done, le_thr- result (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface hamming_acc_seq_if
  import hamming_pkg::*;
#(
  parameter int W      = 8,
  parameter int NBEATS = 2000
);
  localparam int OW = ow_calc(W, NBEATS);

  logic          start;
  logic [OW-1:0] thr;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] o;
  logic          done;
  logic          le_thr;

  modport master (
    output start, thr, x, y, in_valid,
    input  in_ready, o, done, le_thr
  );

  modport slave (
    input  start, thr, x, y, in_valid,
    output in_ready, o, done, le_thr
  );

endinterface : hamming_acc_seq_if
`default_nettype wire

// File: rtl/hamming_popcount.sv
`default_nettype none
// ============================================================================
// Module   : hamming_popcount
// Purpose  : Combinational population count built as a balanced binary adder
//            tree (recursive halving of the input vector).
// Ports    : din [W-1:0]                 - vector to count
//            cnt [popcnt_width(W)-1:0]   - number of ones in din
// Revision : 1.0 - initial release
// ============================================================================
module hamming_popcount
  import hamming_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]               din,
  output logic [popcnt_width(W)-1:0] cnt
);

  localparam int CW = popcnt_width(W);

  generate
    if (W == 1) begin : g_leaf
      assign cnt = din;
    end else begin : g_node
      // Split into two near-equal halves so tree depth stays ceil(log2 W).
      localparam int WL  = W / 2;
      localparam int WH  = W - WL;
      localparam int CWL = popcnt_width(WL);
      localparam int CWH = popcnt_width(WH);

      logic [CWL-1:0] cnt_lo;
      logic [CWH-1:0] cnt_hi;

      hamming_popcount #(.W(WL)) u_lo (
        .din (din[WL-1:0]),
        .cnt (cnt_lo)
      );

      hamming_popcount #(.W(WH)) u_hi (
        .din (din[W-1:WL]),
        .cnt (cnt_hi)
      );

      assign cnt = CW'(cnt_lo) + CW'(cnt_hi);
    end
  endgenerate

endmodule : hamming_popcount
`default_nettype wire

// File: rtl/hamming_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : hamming_acc_seq
// Purpose  : Start/done framed sequential Hamming-distance accumulator.
//            Accepts NBEATS beats of W-bit operand pairs, sums the popcount
//            of x^y per accepted beat and reports the total with a registered
//            "total <= threshold" flag.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous reset, active low
//            bus.slave  - start/thr, x/y/in_valid/in_ready, o/done/le_thr
// Revision : 1.0 - initial release
// ============================================================================
module hamming_acc_seq
  import hamming_pkg::*;
#(
  parameter int W      = 8,
  parameter int NBEATS = 2000
) (
  input  logic                clk,
  input  logic                rst,
  hamming_acc_seq_if.slave    bus
);

  localparam int OW    = ow_calc(W, NBEATS);
  localparam int PW    = popcnt_width(W);
  localparam int CNT_W = beat_cnt_width(NBEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  state_e           state_q, state_d;
  logic [OW-1:0]    o_q, o_d;
  logic [OW-1:0]    thr_q, thr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             le_thr_q, le_thr_d;

  logic [W-1:0]     diff;
  logic [PW-1:0]    pc;
  logic [OW-1:0]    sum_next;
  logic             start_ok;
  logic             accept;
  logic             last_beat;
  logic             in_ready;
  logic             done;

  assign diff = bus.x ^ bus.y;

  hamming_popcount #(.W(W)) u_popcount (
    .din (diff),
    .cnt (pc)
  );

  // start is only meaningful outside ACC; a start mid-computation is dropped.
  assign start_ok  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept    = bus.in_valid && in_ready;
  assign last_beat = (cnt_q == LAST_BEAT);
  assign sum_next  = o_q + OW'(pc);

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok)             state_d = ST_ACC;
      ST_ACC:  if (accept && last_beat)  state_d = ST_DONE;
      ST_DONE: if (start_ok)             state_d = ST_ACC;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // in_ready is a pure function of state, never of in_valid.
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_ACC:  in_ready = 1'b1;
      ST_DONE: done     = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath ----
  always_comb begin
    o_d      = o_q;
    thr_d    = thr_q;
    cnt_d    = cnt_q;
    le_thr_d = le_thr_q;
    if (start_ok) begin
      o_d      = '0;
      thr_d    = bus.thr;
      cnt_d    = '0;
      le_thr_d = 1'b0;
    end else if (accept) begin
      o_d   = sum_next;
      cnt_d = cnt_q + 1'b1;
      // Flag is captured on the same edge that enters DONE, from the final sum.
      if (last_beat) begin
        le_thr_d = (sum_next <= thr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_q      <= '0;
      thr_q    <= '0;
      cnt_q    <= '0;
      le_thr_q <= 1'b0;
    end else begin
      o_q      <= o_d;
      thr_q    <= thr_d;
      cnt_q    <= cnt_d;
      le_thr_q <= le_thr_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.done     = done;
  assign bus.o        = o_q;
  assign bus.le_thr   = le_thr_q;

endmodule : hamming_acc_seq
`default_nettype wire
